// File: rtl/mem_bridge.sv
// CPU-to-device memory bridge: one outstanding request, decoded against N_TGT
// base/limit windows, forwarded rebased to a single target, answered back to the CPU.
module mem_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_TGT  = 5,
    parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE  = {32'h0020_0000, 32'h0010_0000,
                                                    32'h0000_C000, 32'h0000_8000,
                                                    32'h0000_0000},
    parameter logic [N_TGT*ADDR_W-1:0] TGT_LIMIT = {32'hFFFF_FFFF, 32'h001F_FFFF,
                                                    32'h0001_BFFF, 32'h0000_BFFF,
                                                    32'h0000_7FFF},
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req_valid,
    output logic                    cpu_req_ready,
    input  logic                    cpu_req_we,
    input  logic [ADDR_W-1:0]       cpu_req_addr,
    input  logic [DATA_W-1:0]       cpu_req_wdata,
    output logic                    cpu_rsp_valid,
    output logic [DATA_W-1:0]       cpu_rsp_rdata,
    output logic                    cpu_rsp_err,
    output logic [N_TGT-1:0]        tgt_req_valid,
    input  logic [N_TGT-1:0]        tgt_req_ready,
    output logic                    tgt_req_we,
    output logic [ADDR_W-1:0]       tgt_req_addr,
    output logic [DATA_W-1:0]       tgt_req_wdata,
    input  logic [N_TGT-1:0]        tgt_rsp_valid,
    input  logic [N_TGT*DATA_W-1:0] tgt_rsp_rdata,
    output logic [1:0]              dbg_state
);
    localparam int SEL_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;

    logic               dec_hit;
    logic [SEL_W-1:0]   dec_sel;
    logic [ADDR_W-1:0]  dec_off;
    logic               sel_ready;
    logic               sel_rsp;
    logic [DATA_W-1:0]  sel_rdata;
    logic               rsp_capture;
    logic               timeout_hit;

    // Descending scan so the lowest matching window is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        dec_off = cpu_req_addr;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if (cpu_req_addr >= TGT_BASE[i*ADDR_W +: ADDR_W] &&
                cpu_req_addr <= TGT_LIMIT[i*ADDR_W +: ADDR_W]) begin
                dec_hit = 1'b1;
                dec_sel = SEL_W'(i);
                dec_off = cpu_req_addr - TGT_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        sel_ready     = 1'b0;
        sel_rsp       = 1'b0;
        sel_rdata     = '0;
        tgt_req_valid = '0;
        for (int i = 0; i < N_TGT; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready        = tgt_req_ready[i];
                sel_rsp          = tgt_rsp_valid[i];
                sel_rdata        = tgt_rsp_rdata[i*DATA_W +: DATA_W];
                tgt_req_valid[i] = (state_q == ISSUE);
            end
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; the bridge holds its request fields stable until the target's ready.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_capture = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cpu_req_valid) begin
                    state_d = dec_hit ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (sel_ready) begin
                    cnt_d = '0;
                    if (sel_rsp) begin
                        state_d     = RESP;
                        rsp_capture = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    timeout_hit = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (sel_rsp) begin
                    state_d     = RESP;
                    rsp_capture = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    timeout_hit = 1'b1;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && cpu_req_valid) begin
                sel_q   <= dec_sel;
                we_q    <= cpu_req_we;
                addr_q  <= dec_off;
                wdata_q <= cpu_req_wdata;
                rdata_q <= '0;
                err_q   <= ~dec_hit;
            end
            if (rsp_capture) begin
                rdata_q <= we_q ? '0 : sel_rdata;
                err_q   <= 1'b0;
            end
            if (timeout_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign cpu_req_ready = (state_q == IDLE);
    assign cpu_rsp_valid = (state_q == RESP);
    assign cpu_rsp_rdata = rdata_q;
    assign cpu_rsp_err   = err_q;
    assign tgt_req_we    = we_q;
    assign tgt_req_addr  = addr_q;
    assign tgt_req_wdata = wdata_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_mem_bridge.sv
// Bench for mem_bridge: transaction-level timeline model of each request, a per-cycle
// compare process and a response scoreboard, with directed cases then random traffic.
module tb_mem_bridge;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int N_TGT   = 5;
    localparam int TIMEOUT = 255;

    localparam logic [31:0] WIN_BASE  [N_TGT] = '{32'h0000_0000, 32'h0000_8000, 32'h0000_C000,
                                                  32'h0010_0000, 32'h0020_0000};
    localparam logic [31:0] WIN_LIMIT [N_TGT] = '{32'h0000_7FFF, 32'h0000_BFFF, 32'h0001_BFFF,
                                                  32'h001F_FFFF, 32'hFFFF_FFFF};

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cpu_req_valid;
    logic                    cpu_req_ready;
    logic                    cpu_req_we;
    logic [ADDR_W-1:0]       cpu_req_addr;
    logic [DATA_W-1:0]       cpu_req_wdata;
    logic                    cpu_rsp_valid;
    logic [DATA_W-1:0]       cpu_rsp_rdata;
    logic                    cpu_rsp_err;
    logic [N_TGT-1:0]        tgt_req_valid;
    logic [N_TGT-1:0]        tgt_req_ready;
    logic                    tgt_req_we;
    logic [ADDR_W-1:0]       tgt_req_addr;
    logic [DATA_W-1:0]       tgt_req_wdata;
    logic [N_TGT-1:0]        tgt_rsp_valid;
    logic [N_TGT*DATA_W-1:0] tgt_rsp_rdata;
    logic [1:0]              dbg_state;

    mem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_TGT(N_TGT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
        .tgt_req_valid(tgt_req_valid), .tgt_req_ready(tgt_req_ready),
        .tgt_req_we(tgt_req_we), .tgt_req_addr(tgt_req_addr), .tgt_req_wdata(tgt_req_wdata),
        .tgt_rsp_valid(tgt_rsp_valid), .tgt_rsp_rdata(tgt_rsp_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- expectations and scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    logic             exp_cpu_ready;
    logic             exp_rsp_valid;
    logic [N_TGT-1:0] exp_tgt_valid;
    logic             exp_we;
    logic [31:0]      exp_addr;
    logic [31:0]      exp_wdata;
    logic             exp_zero;
    logic [32:0]      exp_q[$];

    int               txn_start;
    int               last_rsp_cyc;
    logic [31:0]      last_rsp_rdata;
    logic             last_rsp_err;
    logic [N_TGT-1:0] last_tgt_valid;
    logic [31:0]      last_tgt_addr;
    logic             last_tgt_we;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cpu_req_ready", 64'(cpu_req_ready), 64'(exp_cpu_ready));
            check("cpu_rsp_valid", 64'(cpu_rsp_valid), 64'(exp_rsp_valid));
            check("tgt_req_valid", 64'(tgt_req_valid), 64'(exp_tgt_valid));
            if (exp_tgt_valid != '0) begin
                check("tgt_req_addr",  64'(tgt_req_addr),  64'(exp_addr));
                check("tgt_req_we",    64'(tgt_req_we),    64'(exp_we));
                check("tgt_req_wdata", 64'(tgt_req_wdata), 64'(exp_wdata));
            end
            if (exp_rsp_valid) begin
                if (exp_q.size() > 0) begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("rsp_err",   64'(cpu_rsp_err),   64'(e[32]));
                    check("rsp_rdata", 64'(cpu_rsp_rdata), 64'(e[31:0]));
                end else begin
                    n_checks++;
                    $display("FAIL rsp_sb: response expected with empty scoreboard (cycle %0d)", cyc);
                end
            end
            if (exp_zero) begin
                check("rst_tgt_addr",  64'(tgt_req_addr),  64'd0);
                check("rst_tgt_we",    64'(tgt_req_we),    64'd0);
                check("rst_tgt_wdata", 64'(tgt_req_wdata), 64'd0);
                check("rst_rsp_rdata", 64'(cpu_rsp_rdata), 64'd0);
                check("rst_rsp_err",   64'(cpu_rsp_err),   64'd0);
            end
            if (cpu_rsp_valid) begin
                last_rsp_cyc   = cyc;
                last_rsp_rdata = cpu_rsp_rdata;
                last_rsp_err   = cpu_rsp_err;
            end
            if (tgt_req_valid != '0) begin
                last_tgt_valid = tgt_req_valid;
                last_tgt_addr  = tgt_req_addr;
                last_tgt_we    = tgt_req_we;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic void model_decode(input logic [31:0] a, output bit hit, output int sel,
                                         output logic [31:0] off);
        hit = 1'b0;
        sel = 0;
        off = '0;
        for (int i = 0; i < N_TGT; i++) begin
            if (!hit && a >= WIN_BASE[i] && a <= WIN_LIMIT[i]) begin
                hit = 1'b1;
                sel = i;
                off = a - WIN_BASE[i];
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            cpu_req_valid = 1'b0;
            cpu_req_we    = 1'($urandom);
            cpu_req_addr  = $urandom;
            cpu_req_wdata = $urandom;
            tgt_req_ready = N_TGT'($urandom);
            tgt_rsp_valid = N_TGT'($urandom);
            for (int i = 0; i < N_TGT; i++) tgt_rsp_rdata[i*DATA_W +: DATA_W] = $urandom;
            exp_cpu_ready = 1'b1;
            exp_rsp_valid = 1'b0;
            exp_tgt_valid = '0;
            @(posedge clk); #1;
        end
    endtask

    // rdy_dly: ISSUE cycles before the target's ready (>= TIMEOUT means never).
    // rsp_dly: cycles from ready to response (0 = same cycle, > TIMEOUT means never).
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                           input bit flood, input int abort_at);
        bit               hit;
        int               sel;
        logic [31:0]      off;
        logic [N_TGT-1:0] oh;
        bit               err;
        int               issue_last;
        int               rsp_at;
        int               resp_cyc;
        int               last_c;
        model_decode(addr, hit, sel, off);
        oh         = hit ? (N_TGT'(1) << sel) : '0;
        err        = !hit;
        issue_last = 0;
        rsp_at     = -1;
        if (!hit) begin
            resp_cyc = 1;
        end else if (rdy_dly >= TIMEOUT) begin
            issue_last = TIMEOUT;
            resp_cyc   = TIMEOUT + 1;
            err        = 1'b1;
        end else begin
            issue_last = 1 + rdy_dly;
            if (rsp_dly > TIMEOUT) begin
                resp_cyc = 2 + rdy_dly + TIMEOUT;
                err      = 1'b1;
            end else begin
                rsp_at   = 1 + rdy_dly + rsp_dly;
                resp_cyc = rsp_at + 1;
            end
        end
        if (abort_at == 0) exp_q.push_back({err, (err || we) ? 32'h0 : rdata});
        last_c = (abort_at != 0) ? abort_at : resp_cyc;

        for (int c = 0; c <= last_c; c++) begin
            if (c == 0) begin
                txn_start      = cyc;
                last_rsp_cyc   = -1;
                last_rsp_rdata = 32'hBAD0_BAD0;
                last_tgt_valid = '0;
                cpu_req_we     = we;
                cpu_req_addr   = addr;
                cpu_req_wdata  = wdata;
            end else begin
                cpu_req_we    = 1'($urandom);
                cpu_req_addr  = $urandom;
                cpu_req_wdata = $urandom;
            end
            cpu_req_valid = (c == 0);
            rst           = (abort_at != 0 && c == abort_at);
            tgt_req_ready = N_TGT'($urandom) & ~oh;
            tgt_rsp_valid = N_TGT'($urandom) & ~oh;
            if (flood) begin
                tgt_req_ready = tgt_req_ready | ~oh;
                tgt_rsp_valid = tgt_rsp_valid | ~oh;
            end
            if (hit && c == issue_last && rdy_dly < TIMEOUT) tgt_req_ready = tgt_req_ready | oh;
            if (c == rsp_at) tgt_rsp_valid = tgt_rsp_valid | oh;
            for (int i = 0; i < N_TGT; i++) tgt_rsp_rdata[i*DATA_W +: DATA_W] = $urandom;
            if (hit) tgt_rsp_rdata[sel*DATA_W +: DATA_W] = rdata;

            exp_cpu_ready = (c == 0);
            exp_rsp_valid = (c == resp_cyc);
            exp_tgt_valid = (hit && c >= 1 && c <= issue_last) ? oh : '0;
            exp_addr      = off;
            exp_we        = we;
            exp_wdata     = wdata;
            @(posedge clk); #1;
        end
        if (abort_at != 0) begin
            rst           = 1'b0;
            cpu_req_valid = 1'b0;
            tgt_req_ready = '0;
            tgt_rsp_valid = '0;
            exp_zero      = 1'b1;
            exp_cpu_ready = 1'b1;
            exp_rsp_valid = 1'b0;
            exp_tgt_valid = '0;
            @(posedge clk); #1;
            exp_zero = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] edges [12];
        int          k;
        edges = '{32'h0, 32'h7FFF, 32'h8000, 32'hBFFF, 32'hC000, 32'h1BFFF, 32'h1C000,
                  32'hFFFFF, 32'h100000, 32'h1FFFFF, 32'h200000, 32'hFFFFFFFF};
        case ($urandom_range(0, 3))
            0: return edges[$urandom_range(0, 11)];
            1: return $urandom;
            2: begin
                k = $urandom_range(0, N_TGT - 1);
                return WIN_BASE[k] + $urandom_range(0, WIN_LIMIT[k] - WIN_BASE[k]);
            end
            default: return 32'h1C000 + $urandom_range(0, 32'hE3FFF);
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        bit          h;
        int          s;
        logic [31:0] o;

        rst = 1'b1;
        cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
        tgt_req_ready = '0; tgt_rsp_valid = '0; tgt_rsp_rdata = '0;
        exp_cpu_ready = 1'b1; exp_rsp_valid = 1'b0; exp_tgt_valid = '0;
        exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_zero = 1'b1;

        model_decode(32'h0000_0010, h, s, o);
        check("pin_bios_sel", 64'(s), 64'd0);
        check("pin_bios_off", 64'(o), 64'h10);
        model_decode(32'h0010_0004, h, s, o);
        check("pin_vga_sel", 64'(s), 64'd3);
        check("pin_vga_off", 64'(o), 64'h4);
        model_decode(32'h000F_0000, h, s, o);
        check("pin_gap_hit", 64'(h), 64'd0);
        model_decode(32'hFFFF_FFFF, h, s, o);
        check("pin_ram_sel", 64'(s), 64'd4);
        check("pin_ram_off", 64'(o), 64'hFFDF_FFFF);
        model_decode(32'h0001_C000, h, s, o);
        check("pin_sound_end", 64'(h), 64'd0);

        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        exp_zero = 1'b0;
        idle(2);

        // BIOS read, ready and response in the same cycle
        run_txn(1'b0, 32'h0000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 0);
        check("tp1_latency", 64'(last_rsp_cyc - txn_start), 64'd2);
        check("tp1_rdata",   64'(last_rsp_rdata), 64'hDEAD_BEEF);
        check("tp1_err",     64'(last_rsp_err), 64'd0);
        check("tp1_tvalid",  64'(last_tgt_valid), 64'b00001);
        check("tp1_taddr",   64'(last_tgt_addr), 64'h10);

        // VGA write
        run_txn(1'b1, 32'h0010_0004, 32'h0000_012B, 1, 1, 32'h1234_5678, 1'b0, 0);
        check("tp2_tvalid", 64'(last_tgt_valid), 64'b01000);
        check("tp2_taddr",  64'(last_tgt_addr), 64'h4);
        check("tp2_twe",    64'(last_tgt_we), 64'd1);
        check("tp2_rdata",  64'(last_rsp_rdata), 64'd0);
        check("tp2_err",    64'(last_rsp_err), 64'd0);

        // unmapped gap
        run_txn(1'b0, 32'h000F_0000, 32'h0, 0, 0, 32'h5555_5555, 1'b0, 0);
        check("tp3_latency", 64'(last_rsp_cyc - txn_start), 64'd1);
        check("tp3_err",     64'(last_rsp_err), 64'd1);
        check("tp3_rdata",   64'(last_rsp_rdata), 64'd0);
        check("tp3_tvalid",  64'(last_tgt_valid), 64'd0);

        // RAM never ready
        run_txn(1'b0, 32'hFFFF_FFFF, 32'h0, TIMEOUT, 0, 32'h7777_7777, 1'b0, 0);
        check("tp4_latency", 64'(last_rsp_cyc - txn_start), 64'd256);
        check("tp4_err",     64'(last_rsp_err), 64'd1);
        check("tp4_rdata",   64'(last_rsp_rdata), 64'd0);

        // sound with delays and other targets shouting
        run_txn(1'b0, 32'h0000_C010, 32'h0, 3, 2, 32'h5A5A_1234, 1'b1, 0);
        check("tp5_latency", 64'(last_rsp_cyc - txn_start), 64'd7);
        check("tp5_rdata",   64'(last_rsp_rdata), 64'h5A5A_1234);
        check("tp5_taddr",   64'(last_tgt_addr), 64'h10);
        check("tp5_tvalid",  64'(last_tgt_valid), 64'b00100);

        // control accepts but never responds
        run_txn(1'b0, 32'h0000_8000, 32'h0, 1, TIMEOUT + 5, 32'h9999_9999, 1'b0, 0);
        check("wait_to_latency", 64'(last_rsp_cyc - txn_start), 64'd258);
        check("wait_to_err",     64'(last_rsp_err), 64'd1);

        // reset during WAIT, then a normal request
        run_txn(1'b0, 32'h0000_0204, 32'h0, 0, 30, 32'hAAAA_AAAA, 1'b0, 6);
        run_txn(1'b0, 32'h0000_8004, 32'h0, 0, 1, 32'h0000_1111, 1'b0, 0);
        check("post_rst_latency", 64'(last_rsp_cyc - txn_start), 64'd3);
        check("post_rst_rdata",   64'(last_rsp_rdata), 64'h1111);
        check("post_rst_taddr",   64'(last_tgt_addr), 64'h4);

        for (int n = 0; n < 150; n++) begin
            int rd;
            int rs;
            rd = ($urandom_range(0, 19) == 0) ? $urandom_range(5, 40) : $urandom_range(0, 4);
            rs = ($urandom_range(0, 19) == 0) ? $urandom_range(5, 40) : $urandom_range(0, 4);
            run_txn(1'($urandom), pick_addr(), $urandom, rd, rs, $urandom,
                    ($urandom_range(0, 3) == 0), 0);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end

        idle(2);
        chk_en = 1'b0;
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
